ksa: RTL and testbench
======================

Name: ksa

Overview:
- ARC4 key-scheduling stage. Runs the 256-iteration KSA swap loop over S memory, using the 24-bit secret key.
- Sits directly upstream of prga. It runs after S has been initialised to the identity (S[k]=k) and before prga starts.
- Shares the s_mem port with the init and prga stages. The top-level arbitration ensures only one stage drives s_mem at a time.
- Uses the same en/rdy handshake as prga.

Parameters:
- KEY_BYTES, 3, number of key bytes cycled through (key length in bytes). The index i mod KEY_BYTES selects the key byte.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  start request. Sampled only while rdy=1.
- rdy  output  1  high when idle and able to accept en.
- key  input  24  secret key. key[23:16] is key byte 0, key[15:8] is key byte 1, key[7:0] is key byte 2.
- s_addr  output  8  S memory address.
- s_rddata  input  8  S memory read data. Valid one cycle after s_addr is presented (synchronous altsyncram).
- s_wrdata  output  8  S memory write data.
- s_wren  output  1  S memory write enable.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-high (rst=1 resets immediately, independent of clk).
- Reset values:
  - rdy=1, s_wren=0, s_addr=0, s_wrdata=0.
  - Internal state: i=0, j=0, kidx=0 (key-byte index), si=0, sj=0. State machine in IDLE.
- Algorithm, for i = 0..255:
  - j = (j + S[i] + keybyte[i mod 3]) mod 256
  - swap S[i] and S[j]
  - All sums are 8-bit and wrap modulo 256.
- Key-byte selection:
  - kidx is a mod-3 counter (0, 1, 2, 0, ...) that advances with i. No divider.
  - kidx=0 selects key[23:16], 1 selects key[15:8], 2 selects key[7:0].
  - key is not registered. It must be held stable while rdy=0.
- State machine (one state per cycle):
  - IDLE: rdy=1, s_wren=0. If en=1, clear i, j and kidx, then go to RD_I. Otherwise stay in IDLE.
  - RD_I: s_addr=i. Go to LD_I.
  - LD_I: si <= s_rddata; j <= j + s_rddata + keybyte[kidx]. Go to RD_J.
  - RD_J: s_addr=j (the updated j). Go to LD_J.
  - LD_J: sj <= s_rddata. Go to WR_I.
  - WR_I: s_addr=i, s_wrdata=sj, s_wren=1. Go to WR_J.
  - WR_J: s_addr=j, s_wrdata=si, s_wren=1.
    - If i==255, go to IDLE.
    - Otherwise i <= i+1, kidx advances, go to RD_I.
- Latency:
  - rdy deasserts in the cycle after en is accepted.
  - rdy stays low for exactly 1536 cycles (256 iterations x 6 states), then returns high.
  - en sampled high in the first IDLE cycle after completion starts a new run.
- s_wren is high only in WR_I and WR_J. At most one memory write occurs per cycle.
- Case i==j: both writes target the same address. The final value is si, which equals the original, so S is unchanged. No special case is needed.
- en is ignored while rdy=0. Holding en high continuously restarts the loop immediately after each completion.
- Reset mid-run:
  - The state machine returns to IDLE immediately and s_wren drops asynchronously.
  - Partially permuted S contents are left as-is. No cleanup write is performed.
- i wrap: the loop terminates on i==255 and never wraps i back to 0 inside a run.

Test Plan:
- Identity S, key=24'h000018, one en pulse:
  - After 3 iterations: S[2]=8'h1B, S[8'h1B]=8'h02, S[0]=0, S[1]=1.
  - After completion, rdy is back to 1 after exactly 1536 cycles.
  - Final S matches a software ARC4 KSA model byte-for-byte.
- Identity S, key=24'h000000: after 3 iterations S[2]=3 and S[3]=2. Final S is a permutation, with each value 0..255 appearing exactly once.
- en toggled repeatedly while rdy=0 (cycles 10..500 of the run): final S and completion cycle are identical to the single-pulse run.
- rst=1 asserted at cycle 700 of a run: rdy=1 and s_wren=0 with no clock edge required. A new en then runs 1536 cycles to completion.
- Bus-protocol check:
  - s_wren is high only on 2 consecutive cycles per 6-cycle iteration.
  - s_addr in WR_I equals the address read in RD_I.
  - No write occurs while rdy=1.

Source files
------------

// File: rtl/ksa_if.sv
// Bundles the ksa start/ready handshake, key and S-memory port into one interface.
// master is the upstream/system side (start, key, memory read data); slave is the ksa engine.
interface ksa_if #(
  parameter int KEY_BYTES = 3
);
  logic                   en;
  logic                   rdy;
  logic [8*KEY_BYTES-1:0] key;
  logic [7:0]             s_addr;
  logic [7:0]             s_rddata;
  logic [7:0]             s_wrdata;
  logic                   s_wren;

  modport master (
    output en, key, s_rddata,
    input  rdy, s_addr, s_wrdata, s_wren
  );

  modport slave (
    input  en, key, s_rddata,
    output rdy, s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/ksa.sv
// ARC4 key-scheduling engine: 256 read/read/write/write swap iterations over S memory,
// six single-cycle states per iteration against a synchronous-read RAM.
module ksa #(
  parameter int KEY_BYTES = 3
) (
  input  logic  clk,
  input  logic  rst,
  ksa_if.slave  bus
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    LD_I,
    RD_J,
    LD_J,
    WR_I,
    WR_J
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;

  logic [7:0]        key_bytes [KEY_BYTES];
  logic [7:0]        key_byte;
  logic [KIDX_W-1:0] kidx_inc;

  logic              rdy_o;
  logic [7:0]        s_addr_o;
  logic [7:0]        s_wrdata_o;
  logic              s_wren_o;

  // Key byte 0 lives in the most significant byte of the key word.
  for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key
    assign key_bytes[gi] = bus.key[8*(KEY_BYTES-1-gi) +: 8];
  end

  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (kidx_q == KIDX_W'(k)) key_byte = key_bytes[k];
    end
  end

  assign kidx_inc = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    kidx_d     = kidx_q;
    si_d       = si_q;
    sj_d       = sj_q;
    rdy_o      = 1'b0;
    s_addr_o   = '0;
    s_wrdata_o = '0;
    s_wren_o   = 1'b0;

    unique case (state_q)
      IDLE: begin
        rdy_o = 1'b1;
        if (bus.en) begin
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = RD_I;
        end
      end
      RD_I: begin
        s_addr_o = i_q;
        state_d  = LD_I;
      end
      LD_I: begin
        si_d    = bus.s_rddata;
        j_d     = j_q + bus.s_rddata + key_byte;
        state_d = RD_J;
      end
      RD_J: begin
        s_addr_o = j_q;
        state_d  = LD_J;
      end
      LD_J: begin
        sj_d    = bus.s_rddata;
        state_d = WR_I;
      end
      WR_I: begin
        s_addr_o   = i_q;
        s_wrdata_o = sj_q;
        s_wren_o   = 1'b1;
        state_d    = WR_J;
      end
      WR_J: begin
        // When i==j this second write restores the original byte, so no special case.
        s_addr_o   = j_q;
        s_wrdata_o = si_q;
        s_wren_o   = 1'b1;
        if (i_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = kidx_inc;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rdy      = rdy_o;
  assign bus.s_addr   = s_addr_o;
  assign bus.s_wrdata = s_wrdata_o;
  assign bus.s_wren   = s_wren_o;

endmodule

// File: tb/tb_ksa.sv
// Bench for ksa: synchronous-read S RAM model, bus-protocol monitor and a software ARC4 KSA
// reference run over an array, exercised with fixed and random keys.
module tb_ksa;

  logic clk;
  logic rst;
  logic load_id;

  ksa_if #(.KEY_BYTES(3)) bus ();

  ksa #(.KEY_BYTES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  logic [7:0] mem      [256];
  logic [7:0] model_s  [256];
  logic [7:0] snap     [256];

  always @(posedge clk) begin
    if (load_id) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.s_wren) begin
      mem[bus.s_addr] <= bus.s_wrdata;
    end
    bus.s_rddata <= mem[bus.s_addr];
  end

  // Protocol monitor: run_cyc is the 1-based cycle number inside a run, 0 when idle.
  int         run_cyc;
  int         prot_err;
  int         wr_cnt;
  int         mon_ph;
  int         mon_idx;
  logic       mon_viol;
  logic [7:0] rdi_addr;
  logic [7:0] rdj_addr;

  initial begin
    run_cyc  = 0;
    prot_err = 0;
    wr_cnt   = 0;
    rdi_addr = '0;
    rdj_addr = '0;
  end

  always @(posedge clk) begin
    if (rst)          run_cyc <= 0;
    else if (bus.rdy) run_cyc <= bus.en ? 1 : 0;
    else              run_cyc <= run_cyc + 1;
  end

  always_comb begin
    mon_viol = 1'b0;
    mon_ph   = 0;
    mon_idx  = 0;
    if (run_cyc >= 1 && run_cyc <= 1536) begin
      mon_ph  = (run_cyc - 1) % 6;
      mon_idx = (run_cyc - 1) / 6;
      if (bus.rdy !== 1'b0) mon_viol = 1'b1;
      if (bus.s_wren !== (mon_ph >= 4)) mon_viol = 1'b1;
      if (mon_ph == 0 && bus.s_addr !== mon_idx[7:0]) mon_viol = 1'b1;
      if (mon_ph == 4 && bus.s_addr !== rdi_addr) mon_viol = 1'b1;
      if (mon_ph == 5 && bus.s_addr !== rdj_addr) mon_viol = 1'b1;
    end else if (bus.rdy !== 1'b1 || bus.s_wren !== 1'b0) begin
      mon_viol = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mon_viol) prot_err <= prot_err + 1;
      if (bus.s_wren) wr_cnt <= wr_cnt + 1;
      if (mon_ph == 0) rdi_addr <= bus.s_addr;
      if (mon_ph == 2) rdj_addr <= bus.s_addr;
    end
  end

  task automatic load_identity();
    @(negedge clk);
    load_id = 1'b1;
    @(negedge clk);
    load_id = 1'b0;
  endtask

  task automatic model_identity();
    for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
  endtask

  // Textbook KSA loop on the model array starting from whatever it currently holds.
  task automatic model_ksa(input logic [23:0] k, input int iters);
    int j;
    int kb;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < iters; i++) begin
      kb = int'((k >> (8 * (2 - (i % 3)))) & 24'hFF);
      j  = (j + int'(model_s[i]) + kb) % 256;
      t          = model_s[i];
      model_s[i] = model_s[j];
      model_s[j] = t;
    end
  endtask

  // mode 0: single en pulse, 1: en toggled randomly in cycles 10..500,
  // 2: en held high through completion, 3: run already started, just wait.
  task automatic run_ksa(input int mode, output int low, output bit to);
    bit done;
    done = 1'b0;
    if (mode != 3) begin
      @(negedge clk);
      bus.en = 1'b1;
      low = 0;
    end else begin
      low = 1;
      bus.en = 1'b0;
    end
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (bus.rdy) begin
        done = 1'b1;
      end else begin
        if (low == 18) for (int k = 0; k < 256; k++) snap[k] = mem[k];
        low++;
        case (mode)
          1:       bus.en = (low >= 10 && low <= 500) ? ($urandom_range(0, 1) == 1) : 1'b0;
          2:       bus.en = 1'b1;
          default: bus.en = 1'b0;
        endcase
      end
    end
    to = !done;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.rdy !== 1'b1)     begin bad++; $display("FAIL reset_rdy got=%b want=1", bus.rdy); end
    total++; if (bus.s_wren !== 1'b0)  begin bad++; $display("FAIL reset_wren got=%b want=0", bus.s_wren); end
    total++; if (bus.s_addr !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h want=00", bus.s_addr); end
    total++; if (bus.s_wrdata !== 8'h00) begin bad++; $display("FAIL reset_wrdata got=%h want=00", bus.s_wrdata); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.rdy !== 1'b1 || bus.s_wren !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset rdy=%b wren=%b want rdy=1 wren=0", bus.rdy, bus.s_wren);
    end
    $display("test_reset: checked");
  endtask

  task automatic test_key18();
    int low; bit to; int w0;
    load_identity();
    bus.key = 24'h000018;
    w0 = wr_cnt;
    run_ksa(0, low, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL key18_timeout got=%0d want=0", to); end
    total++; if (low !== 1536) begin bad++; $display("FAIL key18_latency got=%0d want=1536", low); end
    total++; if (snap[2] !== 8'h1B)  begin bad++; $display("FAIL key18_it3_s2 got=%h want=1b", snap[2]); end
    total++; if (snap[27] !== 8'h02) begin bad++; $display("FAIL key18_it3_s1b got=%h want=02", snap[27]); end
    total++; if (snap[0] !== 8'h00)  begin bad++; $display("FAIL key18_it3_s0 got=%h want=00", snap[0]); end
    total++; if (snap[1] !== 8'h01)  begin bad++; $display("FAIL key18_it3_s1 got=%h want=01", snap[1]); end
    total++; if (wr_cnt - w0 !== 512) begin bad++; $display("FAIL key18_writes got=%0d want=512", wr_cnt - w0); end
    model_identity();
    model_ksa(24'h000018, 256);
    for (int a = 0; a < 256; a++) begin
      total++;
      if (mem[a] !== model_s[a]) begin bad++; $display("FAIL key18_final S[%0d] got=%h want=%h", a, mem[a], model_s[a]); end
    end
    $display("test_key18: key=000018 latency=%0d", low);
  endtask

  task automatic test_key0();
    int low; bit to; int cnt [256];
    load_identity();
    bus.key = 24'h000000;
    run_ksa(0, low, to);
    total++; if (to !== 1'b0 || low !== 1536) begin bad++; $display("FAIL key0_latency got=%0d timeout=%0d want=1536", low, to); end
    total++; if (snap[2] !== 8'h03) begin bad++; $display("FAIL key0_it3_s2 got=%h want=03", snap[2]); end
    total++; if (snap[3] !== 8'h02) begin bad++; $display("FAIL key0_it3_s3 got=%h want=02", snap[3]); end
    for (int v = 0; v < 256; v++) cnt[v] = 0;
    for (int a = 0; a < 256; a++) cnt[mem[a]]++;
    for (int v = 0; v < 256; v++) begin
      total++;
      if (cnt[v] !== 1) begin bad++; $display("FAIL key0_perm value %0d count got=%0d want=1", v, cnt[v]); end
    end
    model_identity();
    model_ksa(24'h000000, 256);
    for (int a = 0; a < 256; a++) begin
      total++;
      if (mem[a] !== model_s[a]) begin bad++; $display("FAIL key0_final S[%0d] got=%h want=%h", a, mem[a], model_s[a]); end
    end
    $display("test_key0: key=000000 latency=%0d", low);
  endtask

  task automatic test_random_keys();
    int low; bit to; logic [23:0] k;
    for (int r = 0; r < 3; r++) begin
      k = 24'($urandom);
      load_identity();
      bus.key = k;
      run_ksa(0, low, to);
      total++; if (to !== 1'b0 || low !== 1536) begin bad++; $display("FAIL rand_latency key=%h got=%0d want=1536", k, low); end
      model_identity();
      model_ksa(k, 3);
      for (int a = 0; a < 256; a++) begin
        total++;
        if (snap[a] !== model_s[a]) begin bad++; $display("FAIL rand_it3 key=%h S[%0d] got=%h want=%h", k, a, snap[a], model_s[a]); end
      end
      model_identity();
      model_ksa(k, 256);
      for (int a = 0; a < 256; a++) begin
        total++;
        if (mem[a] !== model_s[a]) begin bad++; $display("FAIL rand_final key=%h S[%0d] got=%h want=%h", k, a, mem[a], model_s[a]); end
      end
      $display("test_random_keys: key=%h latency=%0d", k, low);
    end
  endtask

  task automatic test_en_toggle();
    int low; bit to; logic [23:0] k;
    k = 24'($urandom);
    load_identity();
    bus.key = k;
    run_ksa(1, low, to);
    total++; if (to !== 1'b0 || low !== 1536) begin bad++; $display("FAIL toggle_latency got=%0d want=1536", low); end
    model_identity();
    model_ksa(k, 256);
    for (int a = 0; a < 256; a++) begin
      total++;
      if (mem[a] !== model_s[a]) begin bad++; $display("FAIL toggle_final S[%0d] got=%h want=%h", a, mem[a], model_s[a]); end
    end
    $display("test_en_toggle: key=%h latency=%0d", k, low);
  endtask

  task automatic test_reset_mid_run();
    int low; bit to; logic [23:0] k;
    k = 24'($urandom);
    load_identity();
    bus.key = k;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    repeat (699) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.rdy !== 1'b1)    begin bad++; $display("FAIL midrst_rdy got=%b want=1", bus.rdy); end
    total++; if (bus.s_wren !== 1'b0) begin bad++; $display("FAIL midrst_wren got=%b want=0", bus.s_wren); end
    total++; if (bus.s_addr !== 8'h00) begin bad++; $display("FAIL midrst_addr got=%h want=00", bus.s_addr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // 116 whole iterations had been written when the run was cut at cycle 700.
    model_identity();
    model_ksa(k, 116);
    for (int a = 0; a < 256; a++) begin
      total++;
      if (mem[a] !== model_s[a]) begin bad++; $display("FAIL midrst_partial S[%0d] got=%h want=%h", a, mem[a], model_s[a]); end
    end
    for (int a = 0; a < 256; a++) model_s[a] = mem[a];
    model_ksa(k, 256);
    run_ksa(0, low, to);
    total++; if (to !== 1'b0 || low !== 1536) begin bad++; $display("FAIL midrst_rerun_latency got=%0d want=1536", low); end
    for (int a = 0; a < 256; a++) begin
      total++;
      if (mem[a] !== model_s[a]) begin bad++; $display("FAIL midrst_rerun S[%0d] got=%h want=%h", a, mem[a], model_s[a]); end
    end
    $display("test_reset_mid_run: key=%h rerun latency=%0d", k, low);
  endtask

  task automatic test_back_to_back();
    int low1; int low2; bit to1; bit to2; logic [23:0] k; int w0;
    k = 24'($urandom);
    load_identity();
    bus.key = k;
    w0 = wr_cnt;
    run_ksa(2, low1, to1);
    total++; if (to1 !== 1'b0 || low1 !== 1536) begin bad++; $display("FAIL b2b_first_latency got=%0d want=1536", low1); end
    @(negedge clk);
    total++; if (bus.rdy !== 1'b0) begin bad++; $display("FAIL b2b_restart rdy got=%b want=0", bus.rdy); end
    run_ksa(3, low2, to2);
    total++; if (to2 !== 1'b0 || low2 !== 1536) begin bad++; $display("FAIL b2b_second_latency got=%0d want=1536", low2); end
    total++; if (wr_cnt - w0 !== 1024) begin bad++; $display("FAIL b2b_writes got=%0d want=1024", wr_cnt - w0); end
    model_identity();
    model_ksa(k, 256);
    model_ksa(k, 256);
    for (int a = 0; a < 256; a++) begin
      total++;
      if (mem[a] !== model_s[a]) begin bad++; $display("FAIL b2b_final S[%0d] got=%h want=%h", a, mem[a], model_s[a]); end
    end
    $display("test_back_to_back: key=%h latencies=%0d,%0d", k, low1, low2);
  endtask

  task automatic test_bus_protocol();
    @(negedge clk);
    total++; if (prot_err !== 0) begin bad++; $display("FAIL bus_protocol violations got=%0d want=0", prot_err); end
    $display("test_bus_protocol: writes observed=%0d", wr_cnt);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    load_id = 1'b0;
    bus.en  = 1'b0;
    bus.key = 24'h000000;
    test_reset();
    test_key18();
    test_key0();
    test_random_keys();
    test_en_toggle();
    test_reset_mid_run();
    test_back_to_back();
    test_bus_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
